// File: rtl/resp_signature_checker_pkg.sv
// Shared definitions for the response signature checker.
//   - FSM state encodings (StIdle / StRun / StDone)
//   - default MISR polynomial and seed
//   - misr_next(): one MISR step, used by the register and by any reference model
package resp_sig_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [15:0] DefaultPoly = 16'h1021;
    localparam logic [15:0] DefaultSeed = 16'hFFFF;

    // Widest signature the helper function supports.
    localparam int unsigned MaxSigW = 32;

    // One MISR step on a w-bit register held in the low bits of sig:
    // shift left, fold in POLY when the MSB falls out, then XOR the 4-bit response.
    function automatic logic [MaxSigW-1:0] misr_next(
        input logic [MaxSigW-1:0] sig,
        input logic [3:0]         din,
        input logic [MaxSigW-1:0] poly,
        input int unsigned        w
    );
        logic [MaxSigW-1:0] mask;
        logic [MaxSigW-1:0] shifted;
        logic [MaxSigW-1:0] fb;
        if (w >= MaxSigW) begin
            mask = '1;
        end else begin
            mask = (MaxSigW'(1) << w) - MaxSigW'(1);
        end
        shifted = (sig << 1) & mask;
        fb      = sig[w-1] ? (poly & mask) : '0;
        return shifted ^ fb ^ {{(MaxSigW-4){1'b0}}, din};
    endfunction

endpackage

// File: rtl/resp_signature_checker_if.sv
// Bus between the checker, its stimulus source and the detection controller.
//   master: drives run control (start, num_vectors, golden_sig) and CUT responses
//           (resp_valid, resp); observes status and results.
//   slave : the checker itself.
interface resp_signature_checker_if #(
    parameter int unsigned SIG_W = 16,
    parameter int unsigned CNT_W = 8
);

    logic             start;
    logic [CNT_W-1:0] num_vectors;
    logic [SIG_W-1:0] golden_sig;
    logic             resp_valid;
    logic [3:0]       resp;

    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;
    logic [CNT_W-1:0] vec_count;
    logic [CNT_W-1:0] hit_count;

    modport master (
        output start, num_vectors, golden_sig, resp_valid, resp,
        input  busy, done, pass, signature, vec_count, hit_count
    );

    modport slave (
        input  start, num_vectors, golden_sig, resp_valid, resp,
        output busy, done, pass, signature, vec_count, hit_count
    );

endinterface

// File: rtl/resp_signature_checker_misr_reg.sv
// Multiple-input signature register compacting a 4-bit response per enabled cycle.
//   clk, rst  : clock and synchronous active-high reset (loads SEED)
//   load_seed : reload SEED (takes priority over enable)
//   enable    : fold din into the signature this cycle
//   din       : 4-bit response
//   sig       : current signature
module misr_reg
    import resp_sig_pkg::*;
#(
    parameter int unsigned      SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DefaultPoly),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DefaultSeed)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_seed,
    input  logic             enable,
    input  logic [3:0]       din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load_seed) begin
            sig_d = SEED;
        end else if (enable) begin
            sig_d = SIG_W'(misr_next(MaxSigW'(sig_q), din, MaxSigW'(POLY), SIG_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/resp_signature_checker.sv
// Response compaction and verdict stage for the AND-chain CUT.
// Folds each accepted {H,G,F,E} response into a MISR, counts vectors and H=1 hits,
// and compares the final signature with the golden value captured at start.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of resp_signature_checker_if
//              in : start, num_vectors, golden_sig, resp_valid, resp
//              out: busy, done, pass, signature, vec_count, hit_count (all registered)
module resp_signature_checker
    import resp_sig_pkg::*;
#(
    parameter int unsigned      SIG_W = 16,
    parameter int unsigned      CNT_W = 8,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DefaultPoly),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DefaultSeed)
) (
    input logic                      clk,
    input logic                      rst,
    resp_signature_checker_if.slave  bus
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [SIG_W-1:0] gold_q, gold_d;
    logic [CNT_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic             pass_q, pass_d;

    logic             misr_load;
    logic             misr_en;
    logic [SIG_W-1:0] sig;
    logic [SIG_W-1:0] sig_next;
    logic [CNT_W-1:0] vec_inc;

    misr_reg #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk       (clk),
        .rst       (rst),
        .load_seed (misr_load),
        .enable    (misr_en),
        .din       (bus.resp),
        .sig       (sig)
    );

    // Value the MISR takes on an accepted beat; needed for the last-beat verdict.
    assign sig_next = SIG_W'(misr_next(MaxSigW'(sig), bus.resp, MaxSigW'(POLY), SIG_W));
    assign vec_inc  = vec_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        gold_d    = gold_q;
        vec_d     = vec_q;
        hit_d     = hit_q;
        pass_d    = pass_q;
        misr_load = 1'b0;
        misr_en   = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                // start beats resp_valid here; responses outside RUN are dropped.
                if (bus.start) begin
                    num_d     = bus.num_vectors;
                    gold_d    = bus.golden_sig;
                    vec_d     = '0;
                    hit_d     = '0;
                    misr_load = 1'b1;
                    if (bus.num_vectors == '0) begin
                        state_d = StDone;
                        pass_d  = (SEED == bus.golden_sig);
                    end else begin
                        state_d = StRun;
                        pass_d  = 1'b0;
                    end
                end
            end
            StRun: begin
                if (bus.resp_valid) begin
                    misr_en = 1'b1;
                    vec_d   = vec_inc;
                    if (bus.resp[3] && (hit_q != '1)) begin
                        hit_d = hit_q + CNT_W'(1);
                    end
                    if (vec_inc == num_q) begin
                        state_d = StDone;
                        pass_d  = (sig_next == gold_q);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            num_q   <= '0;
            gold_q  <= '0;
            vec_q   <= '0;
            hit_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            gold_q  <= gold_d;
            vec_q   <= vec_d;
            hit_q   <= hit_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.busy      = (state_q == StRun);
    assign bus.done      = (state_q == StDone);
    assign bus.pass      = pass_q;
    assign bus.signature = sig;
    assign bus.vec_count = vec_q;
    assign bus.hit_count = hit_q;

endmodule
